// File: rtl/cdb_arbiter.sv
// Result-bus arbiter: one holding entry per execution requester, two CDB broadcast
// slots per cycle, granted round-robin starting at rr_ptr.
module cdb_arbiter #(
    parameter int                 DATA_W      = 32,
    parameter int                 ROB_W       = 6,
    parameter logic [ROB_W-1:0]   INVALID_NUM = 6'b010000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            req_valid,
    input  logic [4*DATA_W-1:0]   req_data,
    input  logic [4*ROB_W-1:0]    req_robNum,
    output logic [3:0]            req_ready,
    input  logic                  flush,
    output logic                  cdbIscast,
    output logic [DATA_W-1:0]     cdbData,
    output logic [ROB_W-1:0]      cdbRobNum,
    output logic                  cdbIscast2,
    output logic [DATA_W-1:0]     cdbData2,
    output logic [ROB_W-1:0]      cdbRobNum2,
    output logic [2:0]            pending_cnt
);

    logic [3:0]        pending;
    logic [DATA_W-1:0] hold_data [4];
    logic [ROB_W-1:0]  hold_tag  [4];
    logic [1:0]        rr_ptr;

    logic              g1_valid;
    logic              g2_valid;
    logic [1:0]        g1_idx;
    logic [1:0]        g2_idx;
    logic [1:0]        scan_idx;
    logic [3:0]        granted;
    logic [3:0]        accept;
    logic [3:0]        pending_next;
    logic [1:0]        rr_next;
    logic              slot1_fire;
    logic              slot2_fire;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // First two pending entries in rotating order from rr_ptr.
    always_comb begin
        g1_valid = 1'b0;
        g2_valid = 1'b0;
        g1_idx   = 2'd0;
        g2_idx   = 2'd0;
        scan_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = rr_ptr + 2'(k);
            if (pending[scan_idx]) begin
                if (!g1_valid) begin
                    g1_valid = 1'b1;
                    g1_idx   = scan_idx;
                end else if (!g2_valid) begin
                    g2_valid = 1'b1;
                    g2_idx   = scan_idx;
                end
            end
        end
    end

    always_comb begin
        granted = 4'b0000;
        if (g1_valid) granted[g1_idx] = 1'b1;
        if (g2_valid) granted[g2_idx] = 1'b1;
    end

    // A requester being granted this edge may refill its entry at the same edge.
    assign req_ready    = (~pending | granted) & {4{~flush}};
    assign accept       = req_valid & req_ready;
    assign pending_next = flush ? 4'b0000 : ((pending & ~granted) | accept);
    assign slot1_fire   = g1_valid & ~flush;
    assign slot2_fire   = g2_valid & ~flush;

    always_comb begin
        rr_next = rr_ptr;
        if (flush)         rr_next = 2'd0;
        else if (g2_valid) rr_next = g2_idx + 2'd1;
        else if (g1_valid) rr_next = g1_idx + 2'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending     <= 4'b0000;
            pending_cnt <= 3'd0;
            rr_ptr      <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                hold_data[i] <= '0;
                hold_tag[i]  <= INVALID_NUM;
            end
        end else begin
            pending     <= pending_next;
            pending_cnt <= popcount4(pending_next);
            rr_ptr      <= rr_next;
            for (int i = 0; i < 4; i++) begin
                if (accept[i]) begin
                    hold_data[i] <= req_data[i*DATA_W +: DATA_W];
                    hold_tag[i]  <= req_robNum[i*ROB_W +: ROB_W];
                end
            end
        end
    end

    // Broadcast registers read the old entry contents, so a same-edge refill is safe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cdbIscast  <= 1'b0;
            cdbData    <= '0;
            cdbRobNum  <= INVALID_NUM;
            cdbIscast2 <= 1'b0;
            cdbData2   <= '0;
            cdbRobNum2 <= INVALID_NUM;
        end else begin
            cdbIscast  <= slot1_fire;
            cdbData    <= slot1_fire ? hold_data[g1_idx] : '0;
            cdbRobNum  <= slot1_fire ? hold_tag[g1_idx]  : INVALID_NUM;
            cdbIscast2 <= slot2_fire;
            cdbData2   <= slot2_fire ? hold_data[g2_idx] : '0;
            cdbRobNum2 <= slot2_fire ? hold_tag[g2_idx]  : INVALID_NUM;
        end
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, broadcast data width.
REQ-002 Parameter: ROB_W, 6, ROB tag width.
REQ-003 Parameter: INVALID_NUM, 6'b010000, tag driven on an idle CDB slot.
REQ-004 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: req_valid  in  4  per-requester result valid (0=ALU0, 1=ALU1, 2=load, 3=branch).
REQ-007 Port: req_data  in  4*DATA_W  packed result data, requester i at bits [i*32+31:i*32].
REQ-008 Port: req_robNum  in  4*ROB_W  packed destination ROB tag, requester i at bits [i*6+5:i*6].
REQ-009 Port: req_ready  out  4  requester i result is accepted this cycle when req_valid[i] and req_ready[i] are both high.
REQ-010 Port: flush  in  1  synchronous squash of all held results.
REQ-011 Port: cdbIscast / cdbData / cdbRobNum  out  1/DATA_W/ROB_W  CDB slot 1 broadcast.
REQ-012 Port: cdbIscast2 / cdbData2 / cdbRobNum2  out  1/DATA_W/ROB_W  CDB slot 2 broadcast.
REQ-013 Port: pending_cnt  out  3  number of held results, 0..4.

Function
REQ-014 Each requester SHALL own one holding entry: pending bit, 32-bit data, 6-bit tag.
REQ-015 The round-robin pointer rr_ptr SHALL be 2 bits wide.
REQ-016 Grant selection SHALL be combinational from the pending bits.
- Scan order: rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4).
- The first pending entry found gets slot 1.
- The second pending entry found gets slot 2.
- At most 2 grants are made per cycle.
REQ-017 At each edge, granted entries SHALL be copied to the registered CDB outputs and their pending bits cleared.
- The matching cdbIscast/cdbIscast2 SHALL be high for exactly one cycle.
REQ-018 Each slot with no grant SHALL drive: Iscast=0, Data=0, RobNum=INVALID_NUM.
REQ-019 Slot 2 SHALL never be active while slot 1 is idle.
REQ-020 rr_ptr update SHALL be:
- 2 grants: (second granted index + 1) mod 4.
- 1 grant: (granted index + 1) mod 4.
- 0 grants: unchanged.
REQ-021 req_ready[i] SHALL equal (!pending[i] | granted[i]) & !flush.
- This allows back-to-back acceptance from the same requester while it is being granted.
REQ-022 An accepted result SHALL set pending[i] and capture the data and tag at the same edge.
- A result held on an idle arbiter SHALL broadcast on the next edge, giving an accept-to-broadcast latency of 1 cycle.
- The result SHALL be broadcast exactly once.
REQ-023 Grant and acceptance for the same requester at one edge SHALL clear the old entry, broadcast it, and hold the new one; no data is lost or duplicated.
REQ-024 flush high at an edge SHALL:
- clear all pending bits;
- accept no input;
- drive both slots idle;
- reset rr_ptr to 0.
REQ-025 flush SHALL take priority over any simultaneous req_valid or grant.
REQ-026 pending_cnt SHALL equal the registered popcount of the pending bits.
REQ-027 Tags SHALL pass through unmodified; the arbiter SHALL NOT compare or merge tags.
- Two requesters holding the same tag are broadcast independently.

Reset
REQ-028 While reset is high, regardless of clock:
- pending = 0, rr_ptr = 0, pending_cnt = 0;
- cdbIscast = cdbIscast2 = 0;
- cdbData = cdbData2 = 0;
- cdbRobNum = cdbRobNum2 = INVALID_NUM.
REQ-029 Reset asserted mid-operation SHALL discard all held results; none SHALL be broadcast after reset is released.
REQ-030 req_ready SHALL read 4'b1111 in the first cycle after reset release, provided flush is low.

Verification
REQ-031 Single request: load requester (index 2) presents data 0x00000040, tag 5 for one cycle.
- Next cycle: cdbIscast=1, cdbData=0x40, cdbRobNum=5, cdbIscast2=0.
- The cycle after: cdbIscast=0.
REQ-032 Four simultaneous requests with tags 1,2,3,4 (requesters 0..3), rr_ptr=0.
- Cycle 1: slot1 tag 1, slot2 tag 2.
- Cycle 2: slot1 tag 3, slot2 tag 4.
- pending_cnt sequence: 4, 2, 0.
REQ-033 Fairness: requesters 0 and 1 assert req_valid continuously with incrementing tags.
- Every cycle both broadcast, one per slot.
- No stall occurs and every tag appears exactly once.
REQ-034 Fairness: requesters 0, 1 and 2 assert req_valid continuously.
- Over 6 cycles, each requester receives exactly 4 grants.
REQ-035 Flush: 3 entries pending, flush=1 with req_valid=4'b1111 at the same edge.
- Next cycle: both slots idle and pending_cnt=0.
- No later broadcast carries the flushed or the offered tags.
REQ-036 Async reset: reset is pulsed between clock edges while 2 entries are pending.
- Outputs go idle immediately.
- With no new requests, no broadcast occurs for 3 subsequent cycles.
